vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_VISIBLE, default 800, active pixels per line.
REQ-002 Parameters H_FRONT, H_SYNC, H_BACK, defaults 56, 120, 64, horizontal front porch, sync and back porch in pixels.
REQ-003 Parameter V_VISIBLE, default 600, active lines per frame.
REQ-004 Parameters V_FRONT, V_SYNC, V_BACK, defaults 37, 6, 23, vertical front porch, sync and back porch in lines.
REQ-005 Parameters HS_POL, VS_POL, default 1, 1: sync asserted high; 0: sync asserted low.
REQ-006 Parameter COLOR_W, default 4, bits per colour channel.
REQ-007 Derived: H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK; V_TOTAL likewise; HCW = clog2(H_TOTAL); VCW = clog2(V_TOTAL).
REQ-008 MAX10_CLK1_50  in  1  system clock; all logic on rising edge.
REQ-009 reset  in  1  synchronous, active-high reset.
REQ-010 pix_ce  in  1  pixel clock enable; timing advances one pixel per cycle with pix_ce=1.
REQ-011 mode  in  2  0 solid colour, 1 colour bars, 2 checkerboard, 3 external pixel data.
REQ-012 solid_rgb  in  3*COLOR_W  {R,G,B} colour for mode 0.
REQ-013 pix_data  in  3*COLOR_W  {R,G,B} external pixel, for mode 3.
REQ-014 pix_req  out  1  external pixel request (fetch strobe).
REQ-015 req_x, req_y  out  HCW, VCW  coordinates of requested pixel.
REQ-016 frame_start  out  1  one-cycle pulse at start of each frame.
REQ-017 VGA_R, VGA_G, VGA_B  out  COLOR_W each  colour outputs.
REQ-018 VGA_HS, VGA_VS  out  1 each  sync outputs.

Function
REQ-019 hcount (0..H_TOTAL-1) and vcount (0..V_TOTAL-1) are registers that advance only on cycles with pix_ce=1; hold otherwise.
REQ-020 hcount wraps H_TOTAL-1 -> 0 and increments vcount in the same cycle; vcount wraps V_TOTAL-1 -> 0.
REQ-021 Line order: visible [0, H_VISIBLE-1], front porch, sync [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1], back porch; frame order identical vertically.
REQ-022 active = (hcount < H_VISIBLE) and (vcount < V_VISIBLE).
REQ-023 pix_req = active and pix_ce (combinational from registered counters); req_x = hcount, req_y = vcount whenever active.
REQ-024 The external source presents pix_data by the next pix_ce cycle after pix_req; the block samples pix_data exactly on that cycle.
REQ-025 Two-stage output pipeline advancing only on pix_ce: stage 1 captures sync, active and pattern colour of current counters; stage 2 drives VGA_* outputs.
REQ-026 VGA_HS, VGA_VS and RGB stay mutually aligned; all lag counters by exactly 2 pix_ce steps.
REQ-027 Sync asserted level = HS_POL / VS_POL during sync region, inverse elsewhere.
REQ-028 RGB = 0 whenever the pixel is not active; no X output in any state.
REQ-029 Mode 1: eight equal bars of width H_VISIBLE/8 (last bar absorbs remainder), order white, yellow, cyan, green, magenta, red, blue, black; full channel = all ones.
REQ-030 Mode 2: white when x[5] XOR y[5] = 1, black otherwise (32-pixel squares).
REQ-031 mode and solid_rgb are latched only at frame_start; mid-frame changes take effect at the next frame.
REQ-032 frame_start = 1 for one cycle when pix_ce=1 and counters are (0,0) (first pixel of frame).
REQ-033 pix_req is asserted in every mode; non-mode-3 outputs ignore pix_data.
REQ-034 pix_ce held low freezes counters, pipeline and outputs.

Reset
REQ-035 reset takes priority over pix_ce; on the cycle after reset=1: hcount=vcount=0, pipeline cleared, RGB=0, VGA_HS=~HS_POL, VGA_VS=~VS_POL, pix_req=0, frame_start=0, latched mode=0, latched solid_rgb=0.
REQ-036 Reset mid-frame restarts at (0,0); first frame_start follows the first pix_ce after reset release.

Verification
REQ-037 Defaults, pix_ce=1 constant: HS high for 120 cycles per 1040-cycle line, first rising edge 858 cycles after reset release; VS high 6 lines of 666.
REQ-038 HS_POL=0, VS_POL=0: syncs idle high, pulse low; widths identical to REQ-037.
REQ-039 pix_ce toggling 1,0,1,0: line period 2080 cycles; outputs hold steady on pix_ce=0 cycles.
REQ-040 mode=3, pix_data = {req_x[3:0], req_y[3:0], 4'h5} returned one pix_ce later: VGA_R at screen pixel (x,y) equals x[3:0]; RGB=0 in blanking.
REQ-041 mode 0->1 switched at vcount=300: rest of frame stays solid_rgb; next frame shows bars, pixel 0 white, pixel 799 black.
REQ-042 reset asserted at hcount=500, vcount=200: next cycle outputs at reset values; after release, counters count from (0,0), frame_start pulses once.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with built-in test patterns and an external pixel fetch port.
// Counters advance on pix_ce; sync and colour leave through a two-stage pipeline so they stay aligned.
module vga_timing_gen #(
    parameter int   H_VISIBLE = 800,
    parameter int   H_FRONT   = 56,
    parameter int   H_SYNC    = 120,
    parameter int   H_BACK    = 64,
    parameter int   V_VISIBLE = 600,
    parameter int   V_FRONT   = 37,
    parameter int   V_SYNC    = 6,
    parameter int   V_BACK    = 23,
    parameter logic HS_POL    = 1'b1,
    parameter logic VS_POL    = 1'b1,
    parameter int   COLOR_W   = 4,
    localparam int  H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK,
    localparam int  V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK,
    localparam int  HCW       = $clog2(H_TOTAL),
    localparam int  VCW       = $clog2(V_TOTAL)
) (
    input  logic                   MAX10_CLK1_50,
    input  logic                   reset,
    input  logic                   pix_ce,
    input  logic [1:0]             mode,
    input  logic [3*COLOR_W-1:0]   solid_rgb,
    input  logic [3*COLOR_W-1:0]   pix_data,
    output logic                   pix_req,
    output logic [HCW-1:0]         req_x,
    output logic [VCW-1:0]         req_y,
    output logic                   frame_start,
    output logic [COLOR_W-1:0]     VGA_R,
    output logic [COLOR_W-1:0]     VGA_G,
    output logic [COLOR_W-1:0]     VGA_B,
    output logic                   VGA_HS,
    output logic                   VGA_VS
);

    localparam int RGB_W    = 3 * COLOR_W;
    localparam int HS_START = H_VISIBLE + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam int BAR_W    = H_VISIBLE / 8;

    logic [HCW-1:0]   hcount;
    logic [VCW-1:0]   vcount;
    logic             h_last, v_last, active, hs_now, vs_now;
    logic [1:0]       mode_q, eff_mode;
    logic [RGB_W-1:0] solid_q, eff_solid, pat_rgb;

    logic             hs_p1, vs_p1, vld_p1, ext_p1;
    logic [RGB_W-1:0] rgb_p1;
    logic             hs_p2, vs_p2;
    logic [RGB_W-1:0] rgb_p2;

    // Bar index found by threshold compares, so no divider is needed; the last bar absorbs the remainder.
    function automatic logic [RGB_W-1:0] bar_rgb(input logic [HCW-1:0] x);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 1; i < 8; i++)
            if (x >= HCW'(i * BAR_W))
                idx = 3'(i);
        return {{COLOR_W{~idx[1]}}, {COLOR_W{~idx[2]}}, {COLOR_W{~idx[0]}}};
    endfunction

    function automatic logic checker_on(input logic [HCW-1:0] x, input logic [VCW-1:0] y);
        return ((32'(x) >> 5) & 32'd1) != ((32'(y) >> 5) & 32'd1);
    endfunction

    assign h_last = (hcount == HCW'(H_TOTAL - 1));
    assign v_last = (vcount == VCW'(V_TOTAL - 1));
    assign active = (hcount < HCW'(H_VISIBLE)) && (vcount < VCW'(V_VISIBLE));
    assign hs_now = (hcount >= HCW'(HS_START)) && (hcount < HCW'(HS_END));
    assign vs_now = (vcount >= VCW'(VS_START)) && (vcount < VCW'(VS_END));

    assign frame_start = !reset && pix_ce && (hcount == '0) && (vcount == '0);
    assign pix_req     = !reset && pix_ce && active;
    assign req_x       = hcount;
    assign req_y       = vcount;

    // The first pixel of a frame already uses the settings being latched on that same cycle.
    assign eff_mode  = frame_start ? mode      : mode_q;
    assign eff_solid = frame_start ? solid_rgb : solid_q;

    always_ff @(posedge MAX10_CLK1_50) begin
        if (reset) begin
            hcount <= '0;
            vcount <= '0;
        end else if (pix_ce) begin
            if (h_last) begin
                hcount <= '0;
                vcount <= v_last ? '0 : vcount + 1'b1;
            end else begin
                hcount <= hcount + 1'b1;
            end
        end
    end

    always_ff @(posedge MAX10_CLK1_50) begin
        if (reset) begin
            mode_q  <= 2'd0;
            solid_q <= '0;
        end else if (frame_start) begin
            mode_q  <= mode;
            solid_q <= solid_rgb;
        end
    end

    always_comb begin
        pat_rgb = '0;
        case (eff_mode)
            2'd0:    pat_rgb = eff_solid;
            2'd1:    pat_rgb = bar_rgb(hcount);
            2'd2:    pat_rgb = {RGB_W{checker_on(hcount, vcount)}};
            default: pat_rgb = '0;
        endcase
        if (!active)
            pat_rgb = '0;
    end

    // Stage 1: sync, active flag and pattern colour of the current counters.
    always_ff @(posedge MAX10_CLK1_50) begin
        if (reset) begin
            hs_p1  <= ~HS_POL;
            vs_p1  <= ~VS_POL;
            vld_p1 <= 1'b0;
            ext_p1 <= 1'b0;
            rgb_p1 <= '0;
        end else if (pix_ce) begin
            hs_p1  <= hs_now ? HS_POL : ~HS_POL;
            vs_p1  <= vs_now ? VS_POL : ~VS_POL;
            vld_p1 <= active;
            ext_p1 <= (eff_mode == 2'd3);
            rgb_p1 <= pat_rgb;
        end
    end

    // Stage 2: output registers; external pixel data arrives on this step, one pix_ce after its request.
    always_ff @(posedge MAX10_CLK1_50) begin
        if (reset) begin
            hs_p2  <= ~HS_POL;
            vs_p2  <= ~VS_POL;
            rgb_p2 <= '0;
        end else if (pix_ce) begin
            hs_p2  <= hs_p1;
            vs_p2  <= vs_p1;
            rgb_p2 <= ext_p1 ? (vld_p1 ? pix_data : '0) : rgb_p1;
        end
    end

    assign VGA_HS = hs_p2;
    assign VGA_VS = vs_p2;
    assign VGA_R  = rgb_p2[RGB_W-1 -: COLOR_W];
    assign VGA_G  = rgb_p2[2*COLOR_W-1 -: COLOR_W];
    assign VGA_B  = rgb_p2[COLOR_W-1:0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-size instance for line timing and bar colours,
// and a reduced-size instance (low-active syncs) checked cycle by cycle against a raster model.
module tb_vga_timing_gen;

    localparam int HV = 84, HF = 4, HSY = 6, HB = 6, HT = HV + HF + HSY + HB;
    localparam int VV = 40, VF = 2, VSY = 3, VB = 3, VT = VV + VF + VSY + VB;
    localparam int FRAME = HT * VT;
    localparam logic [11:0] BARS [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                         12'hF0F, 12'hF00, 12'h00F, 12'h000};
    localparam logic [13:0] S_RST_O = {1'b1, 1'b1, 12'h000};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Default-size instance
    logic        d_reset, d_ce, d_req, d_fs, d_hs, d_vs;
    logic [1:0]  d_mode;
    logic [11:0] d_solid, d_data;
    logic [10:0] d_rx;
    logic [9:0]  d_ry;
    logic [3:0]  d_r, d_g, d_b;

    vga_timing_gen dut (
        .MAX10_CLK1_50(clk), .reset(d_reset), .pix_ce(d_ce), .mode(d_mode),
        .solid_rgb(d_solid), .pix_data(d_data), .pix_req(d_req), .req_x(d_rx),
        .req_y(d_ry), .frame_start(d_fs), .VGA_R(d_r), .VGA_G(d_g), .VGA_B(d_b),
        .VGA_HS(d_hs), .VGA_VS(d_vs)
    );

    // Reduced-size instance
    logic        s_reset, s_ce, s_req, s_fs, s_hs, s_vs;
    logic [1:0]  s_mode;
    logic [11:0] s_solid, s_data;
    logic [6:0]  s_rx;
    logic [5:0]  s_ry;
    logic [3:0]  s_r, s_g, s_b;

    vga_timing_gen #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB),
        .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_W(4)
    ) dut_s (
        .MAX10_CLK1_50(clk), .reset(s_reset), .pix_ce(s_ce), .mode(s_mode),
        .solid_rgb(s_solid), .pix_data(s_data), .pix_req(s_req), .req_x(s_rx),
        .req_y(s_ry), .frame_start(s_fs), .VGA_R(s_r), .VGA_G(s_g), .VGA_B(s_b),
        .VGA_HS(s_hs), .VGA_VS(s_vs)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Expected {hs, vs, rgb} of screen position (x,y) for the reduced instance.
    function automatic logic [13:0] pixel(input int x, input int y, input logic [1:0] md,
                                          input logic [11:0] sol);
        logic hs, vs;
        logic [11:0] c;
        int bar;
        hs = !(x >= HV + HF && x < HV + HF + HSY);
        vs = !(y >= VV + VF && y < VV + VF + VSY);
        c = 12'h000;
        if (x < HV && y < VV) begin
            bar = x / (HV / 8);
            if (bar > 7) bar = 7;
            case (md)
                2'd0:    c = sol;
                2'd1:    c = BARS[bar];
                2'd2:    c = (((x / 32) + (y / 32)) % 2 == 1) ? 12'hFFF : 12'h000;
                default: c = {4'(x), 4'(y), 4'h5};
            endcase
        end
        return {hs, vs, c};
    endfunction

    // Raster model state: pix_ce steps since reset, latched frame settings, two-step output delay.
    int          m_steps = 0;
    bit          m_init = 0;
    logic [1:0]  m_mode;
    logic [11:0] m_solid;
    logic [13:0] o_cur, o_mid;
    bit          pend_v = 0;
    logic [11:0] pend_d;
    int          fs_seen = 0;

    // One cycle of the reduced instance; entered and left at 1 time unit after a rising edge.
    task automatic cyc_s(input logic ce, input logic rst);
        int pos, x, y;
        bit act;
        s_ce = ce;
        s_reset = rst;
        if (pend_v) begin
            s_data = pend_d;
            pend_v = 0;
        end
        @(negedge clk);
        pos = m_steps % FRAME;
        x = pos % HT;
        y = pos / HT;
        act = (x < HV) && (y < VV);
        if (s_fs) fs_seen++;
        if (m_init) begin
            check("s_out", {s_hs, s_vs, s_r, s_g, s_b}, o_cur);
            check("s_pix_req", s_req, !rst && ce && act);
            check("s_frame_start", s_fs, !rst && ce && pos == 0);
            if (act && !rst) check("s_req_xy", {s_rx, s_ry}, {7'(x), 6'(y)});
        end
        if (rst) begin
            m_init = 1;
            m_steps = 0;
            o_cur = S_RST_O;
            o_mid = S_RST_O;
            m_mode = 2'd0;
            m_solid = 12'h000;
        end else if (ce && m_init) begin
            if (pos == 0) begin
                m_mode = s_mode;
                m_solid = s_solid;
            end
            o_cur = o_mid;
            o_mid = pixel(x, y, m_mode, m_solid);
            if (act) begin
                pend_v = 1;
                pend_d = {4'(x), 4'(y), 4'h5};
            end
            m_steps++;
        end
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int          k;
        logic        hs;
        logic        vs;
        logic [11:0] rgb;
    } vec_t;

    vec_t tbl[20];

    initial begin
        int rise[2], n_rise, hs_hi, bad, vs_cnt, hs_cnt, fs0, guard;
        logic prev_hs;
        logic [13:0] prev_o;
        logic [1:0] plan[3];

        // k = cycles after reset release; outputs show pixel x = k-2 of line 0 (line 1 beyond 1041)
        tbl = '{'{0, 0, 0, 12'h000}, '{1, 0, 0, 12'h000}, '{2, 0, 0, 12'hFFF},
                '{101, 0, 0, 12'hFFF}, '{102, 0, 0, 12'hFF0}, '{252, 0, 0, 12'h0FF},
                '{352, 0, 0, 12'h0F0}, '{452, 0, 0, 12'hF0F}, '{552, 0, 0, 12'hF00},
                '{652, 0, 0, 12'h00F}, '{701, 0, 0, 12'h00F}, '{702, 0, 0, 12'h000},
                '{801, 0, 0, 12'h000}, '{857, 0, 0, 12'h000}, '{858, 1, 0, 12'h000},
                '{977, 1, 0, 12'h000}, '{978, 0, 0, 12'h000}, '{1041, 0, 0, 12'h000},
                '{1042, 0, 0, 12'hFFF}, '{1142, 0, 0, 12'hFF0}};

        d_reset = 1; d_ce = 1; d_mode = 2'd1; d_solid = 12'h000; d_data = 12'h000;
        s_reset = 1; s_ce = 1; s_mode = 2'd0; s_solid = 12'h000; s_data = 12'h000;
        repeat (2) begin @(posedge clk); #1; end

        // Default instance held in reset
        @(negedge clk);
        check("d_rst_out", {d_hs, d_vs, d_r, d_g, d_b}, 14'h0);
        check("d_rst_req_fs", {d_req, d_fs}, 2'b00);
        check("d_rst_xy", {d_rx, d_ry}, 21'h0);
        @(posedge clk); #1;
        d_reset = 0;

        // Bar pattern and horizontal timing, pix_ce constantly high
        n_rise = 0; hs_hi = 0; prev_hs = 1'b0;
        for (int k = 0; k <= 1900; k++) begin
            @(negedge clk);
            foreach (tbl[i])
                if (tbl[i].k == k)
                    check($sformatf("d_tbl_k%0d", k), {d_hs, d_vs, d_r, d_g, d_b},
                          {tbl[i].hs, tbl[i].vs, tbl[i].rgb});
            if (k == 0) check("d_first_fs", {d_fs, d_req}, 2'b11);
            if (d_hs && !prev_hs && n_rise < 2) rise[n_rise++] = k;
            if (d_hs && n_rise == 1) hs_hi++;
            prev_hs = d_hs;
            @(posedge clk); #1;
        end
        check("d_hs_rises", n_rise, 2);
        check("d_hs_first_rise", rise[0], 858);
        check("d_line_period", rise[1] - rise[0], 1040);
        check("d_hs_width", hs_hi, 120);

        // Alternating pix_ce: line period doubles, outputs hold across pix_ce=0 cycles
        d_reset = 1;
        repeat (2) begin @(posedge clk); #1; end
        d_reset = 0;
        n_rise = 0; bad = 0; prev_hs = 1'b0; prev_o = '0;
        for (int k = 0; k <= 4000; k++) begin
            d_ce = (k % 2 == 0);
            @(negedge clk);
            if (k > 0 && k % 2 == 0 && {d_hs, d_vs, d_r, d_g, d_b} !== prev_o) bad++;
            if (!d_ce && (d_req || d_fs)) bad++;
            if (d_hs && !prev_hs && n_rise < 2) rise[n_rise++] = k;
            prev_hs = d_hs;
            prev_o = {d_hs, d_vs, d_r, d_g, d_b};
            @(posedge clk); #1;
        end
        check("d_ce_hold_violations", bad, 0);
        check("d_ce_first_rise", rise[0], 1715);
        check("d_ce_line_period", rise[1] - rise[0], 2080);
        d_ce = 0;

        // Reduced instance: reset, then a solid frame switched to bars at line 20
        cyc_s(1, 1);
        cyc_s(1, 1);
        s_mode = 2'd0; s_solid = 12'h3A7;
        vs_cnt = 0; hs_cnt = 0;
        while (m_steps < FRAME) begin
            if (m_steps == 20 * HT) s_mode = 2'd1;
            cyc_s(1, 0);
            if (!s_vs) vs_cnt++;
            if (!s_hs) hs_cnt++;
            if (m_steps == 20 * HT + 10) check("s_solid_after_switch", {s_r, s_g, s_b}, 12'h3A7);
        end
        check("s_vs_width", vs_cnt, VSY * HT);
        check("s_hs_width", hs_cnt, HSY * VT);
        while (m_steps < FRAME + 20 * HT + 50) begin
            cyc_s(1, 0);
            if (m_steps == FRAME + 2)  check("s_bars_px0", {s_r, s_g, s_b}, 12'hFFF);
            if (m_steps == FRAME + 85) check("s_bars_px83", {s_r, s_g, s_b}, 12'h000);
        end

        // Mid-frame reset at (50,20)
        cyc_s(1, 1);
        check("s_rst_mid_out", {s_hs, s_vs, s_r, s_g, s_b}, S_RST_O);
        check("s_rst_mid_xy", {s_rx, s_ry}, 13'h0);
        cyc_s(1, 1);
        fs0 = fs_seen;
        repeat (FRAME) cyc_s(1, 0);
        check("s_fs_after_reset", fs_seen - fs0, 1);

        // Randomised pix_ce over frames in external, checkerboard and bars modes
        plan = '{2'd3, 2'd2, 2'd1};
        for (int f = 0; f < 3; f++) begin
            guard = 0;
            while (m_steps < FRAME * (f + 2) && guard < 20000) begin
                if (m_steps % FRAME == FRAME / 2) begin
                    s_mode = plan[f];
                    s_solid = 12'($urandom);
                end
                cyc_s($urandom_range(0, 3) != 0, 0);
                guard++;
            end
            check($sformatf("s_rand_frame%0d_done", f), guard < 20000, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
